// File: rtl/gpu_pixel_writer_pkg.sv
// gpu_pixel_writer_pkg
// Shared definitions for the pixel writer slice.
// Contents:
//   - screen geometry and coordinate widths
//   - default frame-buffer address width
//   - write-FSM state encoding
package gpu_pixel_writer_pkg;

  localparam int WIDTH_BITS    = 10;
  localparam int HEIGHT_BITS   = 9;
  localparam int ADDR_BITS_DEF = 19;

  localparam logic [WIDTH_BITS-1:0]  SCREEN_WIDTH  = 10'd640;
  localparam logic [HEIGHT_BITS-1:0] SCREEN_HEIGHT = 9'd480;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/gpu_pixel_fifo.sv
// gpu_pixel_fifo
// Synchronous FIFO for {address, colour} pixel entries.
// Ports:
//   clk, n_rst       - clock, asynchronous active-low reset
//   push, din        - write request and data (accepted when not full, or full with a pop)
//   pop              - remove the head entry (ignored when empty)
//   head             - current head entry
//   full, empty      - occupancy flags
//   count            - number of stored entries
// DEPTH must be a power of two and at least 2.
module gpu_pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 27
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer
// Consumes the shape generator's coordinate stream, drops off-screen and
// repeated pixels, converts to linear frame-buffer addresses, buffers them
// and writes them out over a req/ack memory port.
// Ports:
//   clk, n_rst                - clock, asynchronous active-low reset
//   X_i, Y_i, color_i         - generator coordinate and shape colour
//   gen_busy_i, gen_done_i    - generator busy level and done pulse
//   mem_wr_o/addr_o/data_o    - write request, address, data
//   mem_ack_i                 - memory accepts the current write
//   busy_o, done_o            - shape in progress, shape complete pulse
//   overflow_o                - sticky: a pixel was dropped on a full FIFO
module gpu_pixel_writer
  import gpu_pixel_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int COLOR_BITS = 8,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [WIDTH_BITS-1:0]  X_i,
  input  logic [HEIGHT_BITS-1:0] Y_i,
  input  logic [COLOR_BITS-1:0]  color_i,
  input  logic                   gen_busy_i,
  input  logic                   gen_done_i,
  output logic                   mem_wr_o,
  output logic [ADDR_BITS-1:0]   mem_addr_o,
  output logic [COLOR_BITS-1:0]  mem_data_o,
  input  logic                   mem_ack_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o
);

  localparam int ENTRY_BITS = ADDR_BITS + COLOR_BITS;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic                   busy_d;
  logic                   start;
  logic [COLOR_BITS-1:0]  color_q;
  logic                   dedup_valid;
  logic [WIDTH_BITS-1:0]  dedup_x;
  logic [HEIGHT_BITS-1:0] dedup_y;
  logic                   sample_ok;
  logic                   addr_valid;
  logic [ADDR_BITS-1:0]   addr_q;

  logic                   fifo_pop;
  logic                   fifo_push_ok;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [ENTRY_BITS-1:0]  fifo_head;
  logic                   drop;

  wr_state_t              state;
  wr_state_t              state_next;

  logic                   done_latch;
  logic                   done_q;
  logic                   busy_q;
  logic                   overflow_q;
  logic                   finish;

  assign start = gen_busy_i && !busy_d;

  // On the first cycle of a shape the dedup register is stale, so it is
  // treated as invalid even though the clear only lands at the next edge.
  always_comb begin
    sample_ok = gen_busy_i
             && (X_i < SCREEN_WIDTH) && (Y_i < SCREEN_HEIGHT)
             && (start || !dedup_valid || (X_i != dedup_x) || (Y_i != dedup_y));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_d      <= 1'b0;
      color_q     <= '0;
      dedup_valid <= 1'b0;
      dedup_x     <= '0;
      dedup_y     <= '0;
      addr_valid  <= 1'b0;
      addr_q      <= '0;
    end else begin
      busy_d     <= gen_busy_i;
      addr_valid <= sample_ok;
      if (start) color_q <= color_i;
      if (sample_ok) begin
        dedup_valid <= 1'b1;
        dedup_x     <= X_i;
        dedup_y     <= Y_i;
        addr_q      <= ADDR_BITS'(Y_i) * ADDR_BITS'(SCREEN_WIDTH) + ADDR_BITS'(X_i);
      end else if (start) begin
        dedup_valid <= 1'b0;
      end
    end
  end

  assign fifo_pop     = (state == WR_WRITE) && mem_ack_i;
  assign fifo_push_ok = addr_valid && (!fifo_full || fifo_pop);
  assign drop         = addr_valid && fifo_full && !fifo_pop;

  gpu_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_BITS)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (addr_valid),
    .din   ({addr_q, color_q}),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= WR_IDLE;
    else        state <= state_next;
  end

  // The request presents the FIFO head directly; the head only moves on an
  // accepted write, which keeps address/data stable while waiting for ack.
  always_comb begin
    state_next = state;
    mem_wr_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    case (state)
      WR_IDLE: begin
        if (!fifo_empty) state_next = WR_WRITE;
      end
      WR_WRITE: begin
        mem_wr_o                 = 1'b1;
        {mem_addr_o, mem_data_o} = fifo_head;
        if (mem_ack_i && (fifo_count == CNT_W'(1)) && !fifo_push_ok)
          state_next = WR_IDLE;
      end
      default: state_next = WR_IDLE;
    endcase
  end

  assign finish = done_latch && !gen_busy_i && !addr_valid && fifo_empty
               && (state == WR_IDLE);

  // Later assignments take priority: a drop in the start cycle still flags
  // overflow, and completion clears the latch.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_latch <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q     <= 1'b1;
        done_latch <= 1'b0;
        overflow_q <= 1'b0;
      end
      if (gen_done_i) done_latch <= 1'b1;
      if (drop)       overflow_q <= 1'b1;
      if (finish) begin
        done_q     <= 1'b1;
        busy_q     <= 1'b0;
        done_latch <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// tb_gpu_pixel_writer
// Directed bench for gpu_pixel_writer with hand-computed addresses.
// A negedge monitor logs every accepted write and counts done pulses.
module tb_gpu_pixel_writer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [9:0]  X_i = '0;
  logic [8:0]  Y_i = '0;
  logic [7:0]  color_i = '0;
  logic        gen_busy_i = 1'b0;
  logic        gen_done_i = 1'b0;
  logic        mem_wr_o;
  logic [18:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic        mem_ack_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;

  int assert_count = 0;
  int fail_count   = 0;
  int done_cnt     = 0;
  int wr_addr_log[$];
  int wr_data_log[$];

  gpu_pixel_writer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .X_i        (X_i),
    .Y_i        (Y_i),
    .color_i    (color_i),
    .gen_busy_i (gen_busy_i),
    .gen_done_i (gen_done_i),
    .mem_wr_o   (mem_wr_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_ack_i  (mem_ack_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  // A write is accepted at the posedge following a negedge where req and ack are both high.
  always @(negedge clk) begin
    if (n_rst && mem_wr_o && mem_ack_i) begin
      wr_addr_log.push_back(int'(mem_addr_o));
      wr_data_log.push_back(int'(mem_data_o));
    end
    if (done_o) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int x, input int y, input int c);
    gen_busy_i = 1'b1;
    X_i        = 10'(x);
    Y_i        = 9'(y);
    color_i    = 8'(c);
    tick();
  endtask

  task automatic endShape();
    gen_busy_i = 1'b0;
    gen_done_i = 1'b1;
    tick();
    gen_done_i = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int max_cycles);
    int start_cnt;
    start_cnt = done_cnt;
    for (int i = 0; i < max_cycles && done_cnt == start_cnt; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    checkOutput(tag, 32'(done_cnt - start_cnt), 32'd1);
  endtask

  task automatic clearLogs();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  initial begin
    $display("[TB] starting gpu_pixel_writer bench");

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wr", mem_wr_o, 0);
    checkOutput("rst_addr", mem_addr_o, 0);
    checkOutput("rst_data", mem_data_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_ovf", overflow_o, 0);
    n_rst = 1'b1;
    tick();

    // Single pixel (10,2), ack high: request two cycles after sampling edge
    clearLogs();
    mem_ack_i = 1'b1;
    applyStimulus(10, 2, 8'h3C);
    gen_busy_i = 1'b0;
    gen_done_i = 1'b1;
    tick();
    gen_done_i = 1'b0;
    checkOutput("t1_wr_n1", mem_wr_o, 0);
    checkOutput("t1_busy", busy_o, 1);
    tick();
    checkOutput("t1_wr_n2", mem_wr_o, 1);
    checkOutput("t1_addr_n2", mem_addr_o, 1290);
    checkOutput("t1_data_n2", mem_data_o, 8'h3C);
    waitDone("t1_done", 50);
    checkOutput("t1_nwrites", wr_addr_log.size(), 1);
    if (wr_addr_log.size() >= 1) begin
      checkOutput("t1_log_addr", wr_addr_log[0], 1290);
      checkOutput("t1_log_data", wr_data_log[0], 8'h3C);
    end
    checkOutput("t1_busy_end", busy_o, 0);

    // Repeated coordinate is deduplicated
    clearLogs();
    for (int i = 0; i < 4; i++) applyStimulus(5, 5, 8'h11);
    applyStimulus(6, 5, 8'h11);
    endShape();
    waitDone("t2_done", 50);
    checkOutput("t2_nwrites", wr_addr_log.size(), 2);
    if (wr_addr_log.size() >= 2) begin
      checkOutput("t2_addr0", wr_addr_log[0], 3205);
      checkOutput("t2_addr1", wr_addr_log[1], 3206);
      checkOutput("t2_data0", wr_data_log[0], 8'h11);
    end

    // Off-screen coordinates and parked sentinel
    clearLogs();
    applyStimulus(640, 480, 8'h22);
    applyStimulus(700, 3, 8'h22);
    applyStimulus(3, 480, 8'h22);
    endShape();
    waitDone("t3_done", 50);
    checkOutput("t3_nwrites", wr_addr_log.size(), 0);

    // Overflow: 12 pixels with ack held low
    clearLogs();
    mem_ack_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(k, 1, 8'h5A);
      checkOutput($sformatf("t4_ovf_k%0d", k), overflow_o, (k >= 9) ? 32'd1 : 32'd0);
    end
    endShape();
    tick();
    checkOutput("t4_wr_held", mem_wr_o, 1);
    checkOutput("t4_head_addr", mem_addr_o, 640);
    checkOutput("t4_busy", busy_o, 1);
    mem_ack_i = 1'b1;
    waitDone("t4_done", 60);
    checkOutput("t4_nwrites", wr_addr_log.size(), 8);
    for (int i = 0; i < 8 && i < wr_addr_log.size(); i++) begin
      checkOutput($sformatf("t4_addr%0d", i), wr_addr_log[i], 640 + i);
      checkOutput($sformatf("t4_data%0d", i), wr_data_log[i], 8'h5A);
    end
    checkOutput("t4_ovf_sticky", overflow_o, 1);

    // Delayed ack: request held four cycles, next entry follows the ack
    clearLogs();
    mem_ack_i = 1'b0;
    applyStimulus(100, 10, 8'h77);
    applyStimulus(101, 10, 8'h77);
    endShape();
    checkOutput("t5_ovf_cleared", overflow_o, 0);
    for (int i = 0; i < 10 && !mem_wr_o; i++) tick();
    checkOutput("t5_wr_c1", mem_wr_o, 1);
    checkOutput("t5_addr_c1", mem_addr_o, 6500);
    tick();
    checkOutput("t5_wr_c2", mem_wr_o, 1);
    checkOutput("t5_addr_c2", mem_addr_o, 6500);
    tick();
    checkOutput("t5_wr_c3", mem_wr_o, 1);
    checkOutput("t5_data_c3", mem_data_o, 8'h77);
    tick();
    mem_ack_i = 1'b1;
    checkOutput("t5_wr_c4", mem_wr_o, 1);
    checkOutput("t5_addr_c4", mem_addr_o, 6500);
    tick();
    checkOutput("t5_wr_next", mem_wr_o, 1);
    checkOutput("t5_addr_next", mem_addr_o, 6501);
    waitDone("t5_done", 50);
    checkOutput("t5_nwrites", wr_addr_log.size(), 2);
    if (wr_addr_log.size() >= 2) begin
      checkOutput("t5_log0", wr_addr_log[0], 6500);
      checkOutput("t5_log1", wr_addr_log[1], 6501);
    end

    // Asynchronous reset while writing with three entries queued
    clearLogs();
    mem_ack_i = 1'b0;
    applyStimulus(1, 1, 8'h99);
    applyStimulus(2, 1, 8'h99);
    applyStimulus(3, 1, 8'h99);
    tick();
    tick();
    checkOutput("t6_wr_before", mem_wr_o, 1);
    checkOutput("t6_busy_before", busy_o, 1);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("t6_wr_async", mem_wr_o, 0);
    checkOutput("t6_busy_async", busy_o, 0);
    checkOutput("t6_ovf_async", overflow_o, 0);
    gen_busy_i = 1'b0;
    tick();
    n_rst = 1'b1;
    mem_ack_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t6_nwrites", wr_addr_log.size(), 0);
    checkOutput("t6_wr_after", mem_wr_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
